mc_ctrl: RTL
============

Name: mc_ctrl

Overview:
Multicycle control FSM for the RV32I core.
- Sequences instruction fetch, decode, execute, memory and writeback over the shared datapath: IR, PC, ALU, register file, imm_gen and unified memory port.
- Drives imm_gen's imm_sel and all datapath enables and muxes from the IR contents.
- Stalls on a memory ready handshake.

Parameters:
DEC_WAIT, 1, cycles spent in DECODE so imm_gen output settles before EXEC (min 1).
MEM_WAIT_MAX, 15, max consecutive wait cycles on the memory port before bus error (used only with the optional feature).

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-high reset.
inst  input  32  IR output; stable between ir_we pulses.
mem_ready  input  1  memory has completed the current request this cycle.
br_taken  input  1  ALU branch-compare result, valid in EXEC.
imm_sel  output  3  to imm_gen: 001 I, 010 S, 011 B, 100 J, 000 none.
ir_we  output  1  IR load strobe.
pc_we  output  1  PC load strobe.
pc_src  output  2  00 pc+4, 01 pc+imm, 10 (rs1+imm)&~1.
mem_req  output  1  memory request.
mem_we  output  1  store when high.
mem_addr_sel  output  1  0 = PC, 1 = ALU result.
alu_a_sel  output  1  0 = rs1, 1 = PC.
alu_b_sel  output  1  0 = rs2, 1 = imm.
reg_we  output  1  register-file write.
wb_sel  output  2  00 ALU, 01 memory data, 10 pc+4.
illegal  output  1  sticky illegal-instruction flag.
bus_err  output  1  sticky memory-timeout flag (tied 0 without the optional feature).
state  output  3  current state, for debug.

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- Reset: async to FETCH. illegal=0, bus_err=0, wait counters=0. All strobes and selects are 0 while rst is high.
- Reset mid-operation: mem_req drops immediately; memory must tolerate an abandoned request.
- Outputs are combinational from state, the registered counter, inst and br_taken. Every strobe is 0 unless listed for a state below.

Opcode classes (inst[6:0]), each giving imm_sel:
- 0110011 R: 000.
- 0010011 I-ALU: 001.
- 0000011 LOAD: 001.
- 0100011 STORE: 010.
- 1100011 BRANCH: 011.
- 1101111 JAL: 100.
- 1100111 JALR: 001.
- All others (including LUI, AUIPC, SYSTEM, FENCE) are illegal.

Per-state behaviour:
- FETCH: mem_req=1, mem_addr_sel=0, imm_sel=000.
  - mem_ready=0: stay.
  - mem_ready=1: ir_we=1 that cycle, go to DECODE.
- DECODE: imm_sel valid. Counter runs DEC_WAIT cycles.
  - Illegal class: go to TRAP on the first DECODE cycle; illegal is set on TRAP entry.
  - Otherwise go to EXEC when the counter expires.
- imm_sel stays valid from DECODE until the instruction's final cycle.
- EXEC:
  - R/I/LOAD/STORE: alu_b_sel = (class != R).
  - BRANCH: alu_b_sel=0, pc_we=1, pc_src = br_taken ? 01 : 00, go to FETCH (final cycle).
  - JAL/JALR: go to WB.
  - LOAD/STORE: go to MEM. R/I-ALU: go to WB.
- MEM: mem_req=1, mem_addr_sel=1, alu_b_sel=1, mem_we = STORE.
  - Stay until mem_ready.
  - LOAD: go to WB.
  - STORE: pc_we=1, pc_src=00, go to FETCH.
- WB: reg_we=1, pc_we=1, go to FETCH. rd=x0 writes are discarded by the regfile.
  - wb_sel: 00 for R/I, 01 for LOAD, 10 for JAL/JALR.
  - pc_src: 01 for JAL, 10 for JALR, else 00.
- TRAP: all strobes 0, flags held. Exit only via rst.
- Cycle counts with mem_ready immediate and DEC_WAIT=1:
  - R/I/JAL/JALR: 4.
  - BRANCH: 3.
  - LOAD: 5.
  - STORE: 4.
- Every wait state adds 1 cycle.

Optional Feature:
MC_CTRL_MEM_TIMEOUT_EN
- Defined: a counter tracks consecutive FETCH/MEM cycles with mem_ready=0 and clears on mem_ready or state change. When the counter reaches MEM_WAIT_MAX and mem_ready is still 0, the next state is TRAP with bus_err set.
- Undefined: no counter; FETCH/MEM wait indefinitely; bus_err is constant 0.

Decomposition:
- Package ctrl_pkg:
  - opcode constants.
  - imm_sel encodings: IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_J.
  - state enum.
  - pc_src and wb_sel encodings.
  - instruction class enum.
- One natural combinational sub-module, ctrl_decode: inst[6:0] in; class, imm_sel and illegal out.
- The FSM, counters and output logic stay in mc_ctrl.

Test Plan:
1. addi x1,x0,5 (0x00500093), mem_ready=1 in FETCH:
   - States 0,1,2,4 in 4 cycles.
   - imm_sel=001 from DECODE.
   - WB: reg_we=1, wb_sel=00, pc_we=1, pc_src=00.
2. sw x2,8(x1) (0x0020A423), mem_ready held 0 for 3 MEM cycles then 1:
   - imm_sel=010.
   - mem_we=1 for all 4 MEM cycles.
   - pc_we only in the completion cycle; reg_we never asserted.
3. beq x0,x0,+8 (0x00000463):
   - br_taken=1: EXEC gives pc_we=1, pc_src=01, imm_sel=011, then FETCH.
   - br_taken=0: pc_src=00.
4. jal x1,+16 (0x010000EF):
   - imm_sel=100; WB gives wb_sel=10, pc_src=01.
   - jalr x1,0(x1) (0x000080E7): imm_sel=001, pc_src=10.
5. lui x5,1 (0x000012B7):
   - TRAP after 1 DECODE cycle; illegal=1; all strobes 0 for 10 cycles.
   - rst pulse: FETCH, illegal=0.
6. Macro defined, MEM_WAIT_MAX=15, mem_ready=0 from reset:
   - TRAP after 16 FETCH cycles with bus_err=1.
   - Macro undefined: still in FETCH after 100 cycles, bus_err=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the RV32I multicycle control path: opcodes, imm_sel,
// pc_src / wb_sel encodings, FSM state and instruction class.
package ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] IMM_NONE = 3'b000;
  localparam logic [2:0] IMM_I    = 3'b001;
  localparam logic [2:0] IMM_S    = 3'b010;
  localparam logic [2:0] IMM_B    = 3'b011;
  localparam logic [2:0] IMM_J    = 3'b100;

  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_IMM   = 2'b01;
  localparam logic [1:0] PC_JALR  = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CLS_R, CLS_I, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JAL, CLS_JALR, CLS_ILL
  } cls_t;

  // Decoder result bundle
  typedef struct packed {
    cls_t       cls;
    logic [2:0] imm_sel;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/ctrl_decode.sv
// Opcode classifier: maps inst[6:0] to instruction class, imm_gen select and
// an illegal flag for every opcode the core does not implement.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output dec_t       dec
);

  // Pure lookup on the major opcode
  always_comb begin
    dec = '{cls: CLS_ILL, imm_sel: IMM_NONE, illegal: 1'b1};
    case (opcode)
      OP_R:      dec = '{cls: CLS_R,      imm_sel: IMM_NONE, illegal: 1'b0};
      OP_I:      dec = '{cls: CLS_I,      imm_sel: IMM_I,    illegal: 1'b0};
      OP_LOAD:   dec = '{cls: CLS_LOAD,   imm_sel: IMM_I,    illegal: 1'b0};
      OP_STORE:  dec = '{cls: CLS_STORE,  imm_sel: IMM_S,    illegal: 1'b0};
      OP_BRANCH: dec = '{cls: CLS_BRANCH, imm_sel: IMM_B,    illegal: 1'b0};
      OP_JAL:    dec = '{cls: CLS_JAL,    imm_sel: IMM_J,    illegal: 1'b0};
      OP_JALR:   dec = '{cls: CLS_JALR,   imm_sel: IMM_I,    illegal: 1'b0};
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle control FSM for the RV32I core: FETCH/DECODE/EXEC/MEM/WB/TRAP.
// Optional build macro MC_CTRL_MEM_TIMEOUT_EN adds a memory wait timeout that
// traps with a sticky bus_err; without it memory waits are unbounded.
module mc_ctrl
  import ctrl_pkg::*;
#(
  parameter int DEC_WAIT     = 1,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic        mem_ready,
  input  logic        br_taken,
  output logic [2:0]  imm_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        illegal,
  output logic        bus_err,
  output logic [2:0]  state
);

  localparam int DW = (DEC_WAIT < 2) ? 1 : $clog2(DEC_WAIT);

  state_t        state_q, state_d;
  dec_t          dec;
  logic [DW-1:0] dec_cnt_q;
  logic          dec_last;
  logic          illegal_q;
  logic          timeout;
  logic          unused_inst;

  // Only the major opcode steers control; funct/reg fields go to the datapath
  assign unused_inst = ^inst[31:7];

  ctrl_decode u_dec (
    .opcode (inst[6:0]),
    .dec    (dec)
  );

  assign dec_last = (dec_cnt_q == DW'(DEC_WAIT - 1));

`ifdef MC_CTRL_MEM_TIMEOUT_EN
  localparam int TW = $clog2(MEM_WAIT_MAX + 1);

  logic [TW-1:0] to_cnt_q;
  logic          bus_err_q;
  logic          mem_wait;

  assign mem_wait = (state_q == S_FETCH) || (state_q == S_MEM);
  assign timeout  = mem_wait && !mem_ready && (to_cnt_q == TW'(MEM_WAIT_MAX));

  // Consecutive not-ready cycles on the memory port; any handshake or state move restarts it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_q  <= '0;
      bus_err_q <= 1'b0;
    end else begin
      if (mem_ready || (state_d != state_q) || !mem_wait) to_cnt_q <= '0;
      else                                                to_cnt_q <= to_cnt_q + 1'b1;
      if (timeout) bus_err_q <= 1'b1;
    end
  end

  assign bus_err = bus_err_q;
`else
  logic unused_cfg;
  assign unused_cfg = (MEM_WAIT_MAX == 0);
  assign timeout    = 1'b0;
  assign bus_err    = 1'b0;
`endif

  // State, decode-settle counter and sticky illegal flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      dec_cnt_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE && state_d == S_DECODE) dec_cnt_q <= dec_cnt_q + 1'b1;
      else                                            dec_cnt_q <= '0;
      if (state_q == S_DECODE && dec.illegal) illegal_q <= 1'b1;
    end
  end

  // Next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (timeout) state_d = S_TRAP;
                else if (mem_ready) state_d = S_DECODE;
      S_DECODE: if (dec.illegal) state_d = S_TRAP;
                else if (dec_last) state_d = S_EXEC;
      S_EXEC: begin
        case (dec.cls)
          CLS_BRANCH:          state_d = S_FETCH;
          CLS_LOAD, CLS_STORE: state_d = S_MEM;
          default:             state_d = S_WB;
        endcase
      end
      S_MEM:    if (timeout) state_d = S_TRAP;
                else if (mem_ready) state_d = (dec.cls == CLS_STORE) ? S_FETCH : S_WB;
      S_WB:     state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
  end

  // Datapath strobes and selects; everything forced low while in reset so an
  // in-flight memory request is dropped immediately
  always_comb begin
    imm_sel      = IMM_NONE;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = PC_PLUS4;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    alu_a_sel    = 1'b0;
    alu_b_sel    = 1'b0;
    reg_we       = 1'b0;
    wb_sel       = WB_ALU;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          ir_we   = mem_ready;
        end
        S_DECODE: imm_sel = dec.imm_sel;
        S_EXEC: begin
          imm_sel = dec.imm_sel;
          case (dec.cls)
            CLS_I, CLS_LOAD, CLS_STORE: alu_b_sel = 1'b1;
            CLS_BRANCH: begin
              pc_we  = 1'b1;
              pc_src = br_taken ? PC_IMM : PC_PLUS4;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          imm_sel      = dec.imm_sel;
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          alu_b_sel    = 1'b1;
          mem_we       = (dec.cls == CLS_STORE);
          pc_we        = mem_ready && (dec.cls == CLS_STORE);
        end
        S_WB: begin
          imm_sel = dec.imm_sel;
          reg_we  = 1'b1;
          pc_we   = 1'b1;
          case (dec.cls)
            CLS_LOAD: wb_sel = WB_MEM;
            CLS_JAL:  begin wb_sel = WB_PC4; pc_src = PC_IMM;  end
            CLS_JALR: begin wb_sel = WB_PC4; pc_src = PC_JALR; end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign illegal = illegal_q;
  assign state   = state_q;

endmodule
